// File: rtl/dac_pkg.sv
// Shared fixed-point constants and saturation-limit helpers for the DAC scaling datapath.
package dac_pkg;

  localparam int SAMPLE_W       = 16;
  localparam int PROD_W         = 32;
  localparam int SUM_W          = 19;
  localparam int GAIN_FRAC_BITS = 14;
  localparam int ROUND_CONST    = 8192;
  localparam int DAC_DATA_WIDTH_DEF = 14;

  // Clamp limits for a signed DAC word of width dw, expressed in the sum width.
  function automatic logic signed [SUM_W-1:0] sat_hi(input int dw);
    logic signed [SUM_W-1:0] one;
    one = 1;
    return (one <<< (dw - 1)) - one;
  endfunction

  function automatic logic signed [SUM_W-1:0] sat_lo(input int dw);
    logic signed [SUM_W-1:0] one;
    one = 1;
    return -(one <<< (dw - 1));
  endfunction

  localparam logic signed [SUM_W-1:0] DAC_SAT_HI_DEF = sat_hi(DAC_DATA_WIDTH_DEF);
  localparam logic signed [SUM_W-1:0] DAC_SAT_LO_DEF = sat_lo(DAC_DATA_WIDTH_DEF);

endpackage

// File: rtl/dac_scale_sat.sv
// One channel of the scaler: S1 gain multiply, S2 round + offset, S3 clamp to the DAC range.
module dac_scale_sat
  import dac_pkg::*;
#(
  parameter int DAC_DATA_WIDTH = 14
) (
  input  logic                       aclk,
  input  logic                       aresetn,
  input  logic                       ce,
  input  logic signed [SAMPLE_W-1:0] sample,
  input  logic signed [SAMPLE_W-1:0] gain,
  input  logic signed [SAMPLE_W-1:0] offset,
  output logic        [SAMPLE_W-1:0] dout,
  output logic                       sat
);

  localparam logic signed [SUM_W-1:0] SAT_HI = sat_hi(DAC_DATA_WIDTH);
  localparam logic signed [SUM_W-1:0] SAT_LO = sat_lo(DAC_DATA_WIDTH);

  logic signed [PROD_W-1:0] prod_q;
  logic signed [SUM_W-1:0]  sum_q;
  logic        [PROD_W:0]   rnd;
  logic signed [SUM_W-1:0]  sum_d;
  logic signed [SUM_W-1:0]  clip;

  // S1/S2 carry no reset: stage valid bits in the parent qualify their contents.
  always_ff @(posedge aclk) begin
    if (ce) begin
      prod_q <= PROD_W'(sample) * PROD_W'(gain);
      sum_q  <= sum_d;
    end
  end

  always_comb begin
    rnd   = {prod_q[PROD_W-1], prod_q} + (PROD_W+1)'(ROUND_CONST);
    sum_d = rnd[PROD_W:GAIN_FRAC_BITS] + {{(SUM_W-SAMPLE_W){offset[SAMPLE_W-1]}}, offset};
  end

  always_comb begin
    clip = sum_q;
    sat  = 1'b0;
    if (sum_q > SAT_HI) begin
      clip = SAT_HI;
      sat  = 1'b1;
    end else if (sum_q < SAT_LO) begin
      clip = SAT_LO;
      sat  = 1'b1;
    end
  end

  // The clamped value already fits the DAC range, so its low 16 bits are the sign-extended word.
  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      dout <= '0;
    end else if (ce) begin
      dout <= clip[SAMPLE_W-1:0];
    end
  end

endmodule

// File: rtl/axis_dac_scaler.sv
// AXI-Stream two-channel DAC scaler: gain, round, offset and saturate with a saturation counter.
module axis_dac_scaler
  import dac_pkg::*;
#(
  parameter int AXIS_TDATA_WIDTH = 32,
  parameter int DAC_DATA_WIDTH   = 14,
  parameter int CNTR_WIDTH       = 16
) (
  input  logic                        aclk,
  input  logic                        aresetn,
  input  logic [31:0]                 cfg_gain,
  input  logic [31:0]                 cfg_offset,
  input  logic                        cnt_clr,
  output logic [CNTR_WIDTH-1:0]       sts_sat_cnt,
  output logic                        s_axis_tready,
  input  logic [AXIS_TDATA_WIDTH-1:0] s_axis_tdata,
  input  logic                        s_axis_tvalid,
  input  logic                        m_axis_tready,
  output logic [AXIS_TDATA_WIDTH-1:0] m_axis_tdata,
  output logic                        m_axis_tvalid
);

  // Handshake: a beat transfers on a rising edge where valid and ready are both 1. The whole
  // pipeline moves in lockstep on ce, so the input is ready exactly when the output can advance.
  logic ce;
  logic v1_q, v2_q;
  logic sat_a, sat_b;
  logic [SAMPLE_W-1:0] dout_a, dout_b;

  assign ce            = ~m_axis_tvalid | m_axis_tready;
  assign s_axis_tready = ce;

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      v1_q          <= 1'b0;
      v2_q          <= 1'b0;
      m_axis_tvalid <= 1'b0;
    end else if (ce) begin
      v1_q          <= s_axis_tvalid;
      v2_q          <= v1_q;
      m_axis_tvalid <= v2_q;
    end
  end

  dac_scale_sat #(.DAC_DATA_WIDTH(DAC_DATA_WIDTH)) u_ch_a (
    .aclk    (aclk),
    .aresetn (aresetn),
    .ce      (ce),
    .sample  (s_axis_tdata[15:0]),
    .gain    (cfg_gain[15:0]),
    .offset  (cfg_offset[15:0]),
    .dout    (dout_a),
    .sat     (sat_a)
  );

  dac_scale_sat #(.DAC_DATA_WIDTH(DAC_DATA_WIDTH)) u_ch_b (
    .aclk    (aclk),
    .aresetn (aresetn),
    .ce      (ce),
    .sample  (s_axis_tdata[31:16]),
    .gain    (cfg_gain[31:16]),
    .offset  (cfg_offset[31:16]),
    .dout    (dout_b),
    .sat     (sat_b)
  );

  assign m_axis_tdata = AXIS_TDATA_WIDTH'({dout_b, dout_a});

  // Counts beats that clamp as they enter S3; clear wins over increment, and the count sticks at max.
  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      sts_sat_cnt <= '0;
    end else if (cnt_clr) begin
      sts_sat_cnt <= '0;
    end else if (ce && v2_q && (sat_a || sat_b) && (sts_sat_cnt != '1)) begin
      sts_sat_cnt <= sts_sat_cnt + 1'b1;
    end
  end

endmodule
